// File: rtl/udp_image_pkt_ctrl.sv
// udp_image_pkt_ctrl: cuts FWFT pixel FIFO lines into UDP payloads with a 4-byte header.
// Optional tx_done watchdog enabled by UDP_IMG_TX_TIMEOUT_EN.
module udp_image_pkt_ctrl #(
    parameter int IMG_H_PIXEL     = 640,
    parameter int IMG_V_PIXEL     = 480,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int IFG_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    input  logic [10:0] fifo_rd_cnt,
    output logic        fifo_rd_en,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [31:0] tx_data,
    output logic        frame_busy,
    output logic        req_err
);
    localparam int          LINE_BYTES = IMG_H_PIXEL * BYTES_PER_PIXEL;
    localparam logic [15:0] LINE_WORDS = 16'(LINE_BYTES / 4);
    localparam logic [15:0] LAST_LINE  = 16'(IMG_V_PIXEL - 1);
    localparam logic [15:0] GAP_LAST   = 16'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, START, SEND, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] line_idx_q, line_idx_d, word_cnt_q, word_cnt_d, gap_cnt_q, gap_cnt_d;
    logic [7:0]  frame_id_q, frame_id_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        pend_q, pend_d, tx_start_en_q, tx_start_en_d;
    logic        frame_busy_q, frame_busy_d, req_err_q, req_err_d;
    logic        serve, data_word, wd_hit;

    function automatic logic [31:0] swz(input logic [31:0] w);
        return {w[23:16], w[31:24], w[7:0], w[15:8]};
    endfunction

    assign serve       = state_q == SEND && tx_req;
    assign data_word   = word_cnt_q != 16'd0 && word_cnt_q <= LINE_WORDS;
    assign fifo_rd_en  = serve && data_word && !fifo_empty;
    assign tx_byte_num = 16'(LINE_BYTES + 4);
    assign tx_start_en = tx_start_en_q;
    assign tx_data     = tx_data_q;
    assign frame_busy  = frame_busy_q;
    assign req_err     = req_err_q;

`ifdef UDP_IMG_TX_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_q, wd_d;
    assign wd_hit = state_q == SEND && !tx_done && wd_q == WD_LAST;
    assign wd_d   = state_q == SEND ? wd_q + 16'd1 : 16'd0;
    always_ff @(posedge clk or posedge rst)
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        line_idx_d    = line_idx_q;
        word_cnt_d    = word_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_id_d    = frame_id_q;
        tx_data_d     = tx_data_q;
        frame_busy_d  = frame_busy_q;
        tx_start_en_d = 1'b0;
        pend_d        = pend_q | (frame_start && state_q != IDLE);
        req_err_d     = frame_start ? 1'b0 : req_err_q;
        if (serve) begin
            word_cnt_d = word_cnt_q == 16'hFFFF ? word_cnt_q : word_cnt_q + 16'd1;
            if (word_cnt_q == 16'd0) tx_data_d = swz({8'hA5, frame_id_q, line_idx_q});
            else if (!data_word) req_err_d = 1'b1;
            else if (fifo_empty) begin
                tx_data_d = '0;
                req_err_d = 1'b1;
            end else tx_data_d = swz(fifo_dout);
        end
        if (wd_hit) req_err_d = 1'b1;
        case (state_q)
            IDLE: if (frame_start) begin
                line_idx_d   = '0;
                frame_busy_d = 1'b1;
                state_d      = WAIT_DATA;
            end
            WAIT_DATA: if ({5'd0, fifo_rd_cnt} >= LINE_WORDS) begin
                tx_start_en_d = 1'b1;
                state_d       = START;
            end
            START: begin
                word_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: if (tx_done || wd_hit) begin
                gap_cnt_d = '0;
                state_d   = GAP;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_cnt_q >= GAP_LAST) begin
                    if (pend_d) begin
                        pend_d     = 1'b0;
                        line_idx_d = '0;
                        frame_id_d = frame_id_q + 8'd1;
                        state_d    = WAIT_DATA;
                    end else if (line_idx_q == LAST_LINE) begin
                        frame_id_d   = frame_id_q + 8'd1;
                        frame_busy_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        line_idx_d = line_idx_q + 16'd1;
                        state_d    = WAIT_DATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            line_idx_q    <= '0;
            word_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            frame_id_q    <= '0;
            tx_data_q     <= '0;
            pend_q        <= 1'b0;
            tx_start_en_q <= 1'b0;
            frame_busy_q  <= 1'b0;
            req_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_idx_q    <= line_idx_d;
            word_cnt_q    <= word_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_id_q    <= frame_id_d;
            tx_data_q     <= tx_data_d;
            pend_q        <= pend_d;
            tx_start_en_q <= tx_start_en_d;
            frame_busy_q  <= frame_busy_d;
            req_err_q     <= req_err_d;
        end
    end
endmodule

// File: tb/tb_udp_image_pkt_ctrl.sv
// tb_udp_image_pkt_ctrl: directed bench for udp_image_pkt_ctrl with a 4-line frame.
module tb_udp_image_pkt_ctrl;
    logic        clk = 1'b0, rst = 1'b1, frame_start = 1'b0, fifo_empty = 1'b0;
    logic        tx_req = 1'b0, tx_done = 1'b0;
    logic [10:0] fifo_rd_cnt = 11'd0;
    logic [31:0] fifo_dout, tx_data;
    logic [15:0] tx_byte_num;
    logic        fifo_rd_en, tx_start_en, frame_busy, req_err;
    int          total = 0, bad = 0, pops = 0, starts = 0, cyc = 0, start_cyc = 0, done_cyc = 0;

    udp_image_pkt_ctrl #(.IMG_V_PIXEL(4), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_cnt(fifo_rd_cnt), .fifo_rd_en(fifo_rd_en),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num), .tx_data(tx_data), .frame_busy(frame_busy), .req_err(req_err)
    );

    always #4 clk = ~clk;
    assign fifo_dout = 32'h1122_3344 + 32'(pops);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) pops <= pops + 1;
        if (tx_start_en) starts <= starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(output logic [31:0] d);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        d = tx_data;
        tick();
    endtask

    task automatic done;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        done_cyc = cyc;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!tx_start_en && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(tx_start_en), 32'd1);
        start_cyc = cyc;
    endtask

    // mode 1: frame_start right after the header; mode 2: empty FIFO on first data request
    task automatic run_pkt(input string tag, input logic [31:0] hdr, input bit gap_chk, input int mode);
        logic [31:0] d;
        int p0, n;
        wait_start({tag, "_start"});
        if (gap_chk) chk({tag, "_ifg"}, 32'(start_cyc - done_cyc >= 16), 32'd1);
        tick();
        p0 = pops;
        n = 320;
        req(d);
        chk({tag, "_hdr"}, d, hdr);
        if (mode == 1) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        if (mode == 2) begin
            fifo_empty = 1'b1;
            req(d);
            fifo_empty = 1'b0;
            chk({tag, "_empty_data"}, d, 32'h0);
            chk({tag, "_empty_err"}, 32'(req_err), 32'd1);
            chk({tag, "_empty_pop"}, 32'(pops - p0), 32'd0);
            n = 319;
        end
        for (int i = 0; i < n; i++) req(d);
        chk({tag, "_pops"}, 32'(pops - p0), 32'(n));
        done();
    endtask

    initial begin
        logic [31:0] d, last;
        int p0;
        tick();
        tick();
        chk("rst_start", 32'(tx_start_en), 32'd0);
        chk("rst_data", tx_data, 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_err", 32'(req_err), 32'd0);
        chk("rst_bytes", 32'(tx_byte_num), 32'd1284);
        rst = 1'b0;
        tick();
        fifo_rd_cnt = 11'd319;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_rise", 32'(frame_busy), 32'd1);
        repeat (30) tick();
        chk("no_start_319", 32'(starts), 32'd0);
        fifo_rd_cnt = 11'd320;
        tick();
        chk("start_320", 32'(tx_start_en), 32'd1);
        start_cyc = cyc;
        tick();
        chk("start_one_cycle", 32'(tx_start_en), 32'd0);
        chk("bytes", 32'(tx_byte_num), 32'd1284);
        p0 = pops;
        req(d);
        chk("f0l0_hdr", d, 32'h00A5_0000);
        req(d);
        chk("swz_0", d, 32'h2211_4433);
        req(d);
        chk("swz_1", d, 32'h2211_4533);
        for (int i = 0; i < 318; i++) req(d);
        chk("f0l0_pops", 32'(pops - p0), 32'd320);
        chk("no_err_321", 32'(req_err), 32'd0);
        last = tx_data;
        req(d);
        chk("over_err", 32'(req_err), 32'd1);
        chk("over_data", d, last);
        chk("over_pop", 32'(pops - p0), 32'd320);
        done();
        chk("one_start", 32'(starts), 32'd1);
        run_pkt("f0l1", 32'h00A5_0100, 1'b1, 0);
        run_pkt("f0l2", 32'h00A5_0200, 1'b1, 0);
        run_pkt("f0l3", 32'h00A5_0300, 1'b1, 0);
        repeat (25) tick();
        chk("busy_fall", 32'(frame_busy), 32'd0);
        chk("four_starts", 32'(starts), 32'd4);
        chk("err_sticky", 32'(req_err), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("err_clear", 32'(req_err), 32'd0);
        run_pkt("f1l0", 32'h01A5_0000, 1'b0, 0);
        run_pkt("f1l1", 32'h01A5_0100, 1'b1, 0);
        run_pkt("f1l2", 32'h01A5_0200, 1'b1, 1);
        chk("restart_busy", 32'(frame_busy), 32'd1);
        run_pkt("f2l0", 32'h02A5_0000, 1'b1, 0);
        run_pkt("f2l1", 32'h02A5_0100, 1'b1, 2);
`ifdef UDP_IMG_TX_TIMEOUT_EN
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_start("wd_start");
        tick();
        req(d);
        chk("wd_hdr", d, 32'h03A5_0000);
        chk("wd_err_pre", 32'(req_err), 32'd0);
        repeat (210) tick();
        chk("wd_err", 32'(req_err), 32'd1);
        wait_start("wd_advance");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
